// File: rtl/nk_board_ctrl.sv
// N x N, K-in-a-row game board controller: cell storage, turn alternation,
// lowest-index move arbitration, win/draw detection and new-game restart.
module nk_board_ctrl #(
   parameter int N = 3,
   parameter int K = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        new_game,
   input  logic [N*N-1:0]              buttons,
   output logic [2*N*N-1:0]            cells,
   output logic                        player,
   output logic                        move_made,
   output logic [$clog2(N*N)-1:0]      move_idx,
   output logic [$clog2(N*N):0]        move_count,
   output logic                        game_over,
   output logic                        winner,
   output logic                        draw
);

   localparam int C  = N * N;
   localparam int IW = $clog2(N * N);
   localparam logic [IW:0] CNT_ONE  = {{IW{1'b0}}, 1'b1};
   localparam logic [IW:0] CNT_FULL = (IW+1)'(C);

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_CHECK = 2'd1,
      ST_WIN   = 2'd2,
      ST_DRAW  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [2*C-1:0]     cells_q, cells_d;
   logic               player_q, player_d;
   logic               start_player_q, start_player_d;
   logic               last_player_q, last_player_d;
   logic [IW:0]        move_count_q, move_count_d;
   logic               winner_q, winner_d;
   logic               game_over_q, game_over_d;
   logic               draw_q, draw_d;

   logic [C-1:0]       empty_s;
   logic [C-1:0]       cand_s;
   logic [C-1:0]       sel_s;
   logic [IW-1:0]      idx_s;
   logic               found_s;
   logic               move_made_s;
   logic [1:0]         tgt_s;
   logic [C-1:0]       run_h_s, run_v_s, run_d_s, run_a_s;
   logic               win_s;

   // Empty-cell mask from the high bit of each cell code
   always_comb begin
      empty_s = '0;
      for (int i = 0; i < C; i++) begin
         empty_s[i] = ~cells_q[2*i+1];
      end
   end

   assign cand_s = buttons & empty_s;

   // Lowest-index arbitration: one-hot select plus its index
   always_comb begin
      sel_s   = '0;
      idx_s   = '0;
      found_s = 1'b0;
      for (int i = 0; i < C; i++) begin
         sel_s[i] = cand_s[i] & ~found_s;
         idx_s    = sel_s[i] ? IW'(i) : idx_s;
         found_s  = found_s | cand_s[i];
      end
   end

   assign move_made_s = (state_q == ST_PLAY) && (|cand_s);
   assign tgt_s       = {1'b1, last_player_q};

   // Every run start position in each of the four directions gets a match bit;
   // positions whose run would leave the board tie their bit low.
   for (genvar gr = 0; gr < N; gr++) begin : g_row
      for (genvar gc = 0; gc < N; gc++) begin : g_col
         localparam int P = gr * N + gc;
         if (gc + K <= N) begin : g_h
            logic [K-1:0] m;
            for (genvar gk = 0; gk < K; gk++) begin : g_k
               assign m[gk] = (cells_q[2*(P+gk) +: 2] == tgt_s);
            end
            assign run_h_s[P] = &m;
         end else begin : g_nh
            assign run_h_s[P] = 1'b0;
         end
         if (gr + K <= N) begin : g_v
            logic [K-1:0] m;
            for (genvar gk = 0; gk < K; gk++) begin : g_k
               assign m[gk] = (cells_q[2*(P+gk*N) +: 2] == tgt_s);
            end
            assign run_v_s[P] = &m;
         end else begin : g_nv
            assign run_v_s[P] = 1'b0;
         end
         if ((gr + K <= N) && (gc + K <= N)) begin : g_d
            logic [K-1:0] m;
            for (genvar gk = 0; gk < K; gk++) begin : g_k
               assign m[gk] = (cells_q[2*(P+gk*(N+1)) +: 2] == tgt_s);
            end
            assign run_d_s[P] = &m;
         end else begin : g_nd
            assign run_d_s[P] = 1'b0;
         end
         if ((gr + K <= N) && (gc >= K - 1)) begin : g_a
            logic [K-1:0] m;
            for (genvar gk = 0; gk < K; gk++) begin : g_k
               assign m[gk] = (cells_q[2*(P+gk*(N-1)) +: 2] == tgt_s);
            end
            assign run_a_s[P] = &m;
         end else begin : g_na
            assign run_a_s[P] = 1'b0;
         end
      end
   end

   assign win_s = |{run_h_s, run_v_s, run_d_s, run_a_s};

   // Next-state computation; new_game overrides whatever the FSM decided
   always_comb begin
      state_d        = state_q;
      cells_d        = cells_q;
      player_d       = player_q;
      start_player_d = start_player_q;
      last_player_d  = last_player_q;
      move_count_d   = move_count_q;
      winner_d       = winner_q;

      case (state_q)
         ST_PLAY: begin
            if (move_made_s) begin
               for (int i = 0; i < C; i++) begin
                  cells_d[2*i +: 2] = sel_s[i] ? {1'b1, player_q} : cells_q[2*i +: 2];
               end
               move_count_d  = move_count_q + CNT_ONE;
               last_player_d = player_q;
               state_d       = ST_CHECK;
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_CHECK: begin
            if (win_s) begin
               winner_d = last_player_q;
               state_d  = ST_WIN;
            end else if (move_count_q == CNT_FULL) begin
               state_d = ST_DRAW;
            end else begin
               player_d = ~last_player_q;
               state_d  = ST_PLAY;
            end
         end
         ST_WIN:  state_d = ST_WIN;
         ST_DRAW: state_d = ST_DRAW;
         default: state_d = ST_PLAY;
      endcase

      if (new_game) begin
         cells_d        = '0;
         move_count_d   = '0;
         winner_d       = 1'b0;
         state_d        = ST_PLAY;
         start_player_d = ~start_player_q;
         player_d       = ~start_player_q;
      end else begin
         start_player_d = start_player_q;
      end

      game_over_d = (state_d == ST_WIN) || (state_d == ST_DRAW);
      draw_d      = (state_d == ST_DRAW);
   end

   // State and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_PLAY;
         cells_q        <= '0;
         player_q       <= 1'b0;
         start_player_q <= 1'b0;
         last_player_q  <= 1'b0;
         move_count_q   <= '0;
         winner_q       <= 1'b0;
         game_over_q    <= 1'b0;
         draw_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cells_q        <= cells_d;
         player_q       <= player_d;
         start_player_q <= start_player_d;
         last_player_q  <= last_player_d;
         move_count_q   <= move_count_d;
         winner_q       <= winner_d;
         game_over_q    <= game_over_d;
         draw_q         <= draw_d;
      end
   end

   assign cells      = cells_q;
   assign player     = player_q;
   assign move_made  = move_made_s;
   assign move_idx   = idx_s;
   assign move_count = move_count_q;
   assign game_over  = game_over_q;
   assign winner     = winner_q;
   assign draw       = draw_q;

endmodule

// File: tb/tb_nk_board_ctrl.sv
// Directed bench for nk_board_ctrl: a 3x3/K=3 board and a 5x5/K=4 board.
module tb_nk_board_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst3, ng3, pl3, mm3, go3, win3, dr3;
   logic [8:0]  b3;
   logic [17:0] cells3;
   logic [3:0]  mi3;
   logic [4:0]  mc3;

   logic        rst5, ng5, pl5, mm5, go5, win5, dr5;
   logic [24:0] b5;
   logic [49:0] cells5;
   logic [4:0]  mi5;
   logic [5:0]  mc5;

   int n_checks = 0;
   int n_pass   = 0;

   int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
   int seq_anti [6] = '{0, 2, 1, 4, 8, 6};
   int seq_win9 [9] = '{0, 3, 1, 4, 5, 7, 6, 8, 2};
   int seq_a5   [5] = '{2, 0, 7, 1, 12};
   int seq_b5   [7] = '{7, 0, 12, 1, 17, 3, 22};

   nk_board_ctrl #(.N(3), .K(3)) u_dut3 (
      .clk(clk), .rst(rst3), .new_game(ng3), .buttons(b3), .cells(cells3),
      .player(pl3), .move_made(mm3), .move_idx(mi3), .move_count(mc3),
      .game_over(go3), .winner(win3), .draw(dr3)
   );

   nk_board_ctrl #(.N(5), .K(4)) u_dut5 (
      .clk(clk), .rst(rst5), .new_game(ng5), .buttons(b5), .cells(cells5),
      .player(pl5), .move_made(mm5), .move_idx(mi5), .move_count(mc5),
      .game_over(go5), .winner(win5), .draw(dr5)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Press one cell for a single cycle, then let the CHECK cycle pass.
   task automatic press3(input int idx);
      b3 = 9'd1 << idx;
      #1;
      chk("p3_made", mm3, 64'd1);
      chk("p3_idx", mi3, 64'(idx));
      tick();
      b3 = 9'd0;
      tick();
   endtask

   task automatic press5(input int idx);
      b5 = 25'd1 << idx;
      #1;
      chk("p5_made", mm5, 64'd1);
      chk("p5_idx", mi5, 64'(idx));
      tick();
      b5 = 25'd0;
      tick();
   endtask

   initial begin
      rst3 = 1'b1; rst5 = 1'b1; ng3 = 1'b0; ng5 = 1'b0; b3 = 9'd0; b5 = 25'd0;
      @(negedge clk);
      tick();
      tick();
      chk("rst_cells", cells3, 64'd0);
      chk("rst_player", pl3, 64'd0);
      chk("rst_count", mc3, 64'd0);
      chk("rst_over", go3, 64'd0);
      chk("rst_draw", dr3, 64'd0);
      chk("rst_winner", win3, 64'd0);
      chk("rst_made", mm3, 64'd0);
      chk("rst_cells5", cells5, 64'd0);
      rst3 = 1'b0;
      rst5 = 1'b0;

      // Row 0 win by player0, with exact game_over latency
      press3(0); press3(3); press3(1); press3(4);
      b3 = 9'd4;
      #1;
      chk("g1_made", mm3, 64'd1);
      chk("g1_idx", mi3, 64'd2);
      tick();
      b3 = 9'd0;
      chk("g1_over_t1", go3, 64'd0);
      chk("g1_cells", cells3, 64'h003EA);
      tick();
      chk("g1_over_t2", go3, 64'd1);
      chk("g1_winner", win3, 64'd0);
      chk("g1_draw", dr3, 64'd0);
      chk("g1_count", mc3, 64'd5);
      b3 = 9'h1FF;
      #1;
      chk("g1_frozen_made", mm3, 64'd0);
      tick();
      b3 = 9'd0;
      chk("g1_frozen_cells", cells3, 64'h003EA);

      // new_game in WIN: board clears, player1 opens
      ng3 = 1'b1;
      tick();
      ng3 = 1'b0;
      chk("ng1_cells", cells3, 64'd0);
      chk("ng1_count", mc3, 64'd0);
      chk("ng1_over", go3, 64'd0);
      chk("ng1_player", pl3, 64'd1);

      // Full board with no line
      foreach (seq_draw[i]) press3(seq_draw[i]);
      chk("dr_draw", dr3, 64'd1);
      chk("dr_over", go3, 64'd1);
      chk("dr_count", mc3, 64'd9);
      chk("dr_cells", cells3, 64'h3EAFB);

      ng3 = 1'b1;
      tick();
      ng3 = 1'b0;
      chk("ng2_cells", cells3, 64'd0);
      chk("ng2_player", pl3, 64'd0);

      // Anti-diagonal win for player1
      foreach (seq_anti[i]) press3(seq_anti[i]);
      chk("ad_winner", win3, 64'd1);
      chk("ad_draw", dr3, 64'd0);
      chk("ad_over", go3, 64'd1);
      chk("ad_cells", cells3, 64'h2333A);
      b3 = 9'h1FF;
      #1;
      chk("ad_frozen_made", mm3, 64'd0);
      tick();
      tick();
      b3 = 9'd0;
      chk("ad_frozen_cells", cells3, 64'h2333A);

      // Ninth move completes a line: WIN beats DRAW
      ng3 = 1'b1;
      tick();
      ng3 = 1'b0;
      chk("ng3_player", pl3, 64'd1);
      for (int i = 0; i < 8; i++) press3(seq_win9[i]);
      chk("w9_over_pre", go3, 64'd0);
      press3(seq_win9[8]);
      chk("w9_over", go3, 64'd1);
      chk("w9_winner", win3, 64'd1);
      chk("w9_draw", dr3, 64'd0);
      chk("w9_count", mc3, 64'd9);

      // Arbitration among simultaneous presses
      ng3 = 1'b1;
      tick();
      ng3 = 1'b0;
      chk("ng4_player", pl3, 64'd0);
      press3(5);
      b3 = 9'h1A0;
      #1;
      chk("arb_made", mm3, 64'd1);
      chk("arb_idx", mi3, 64'd7);
      tick();
      b3 = 9'd0;
      chk("arb_cells", cells3, 64'h0C800);
      tick();
      chk("arb_count", mc3, 64'd2);
      chk("arb_player", pl3, 64'd0);
      b3 = 9'h0A0;
      #1;
      chk("occ_made", mm3, 64'd0);
      tick();
      tick();
      b3 = 9'd0;
      chk("occ_cells", cells3, 64'h0C800);
      chk("occ_count", mc3, 64'd2);
      chk("occ_player", pl3, 64'd0);

      // new_game discards a simultaneous move
      b3 = 9'h001;
      ng3 = 1'b1;
      #1;
      chk("ngm_made", mm3, 64'd1);
      tick();
      b3 = 9'd0;
      ng3 = 1'b0;
      chk("ngm_cells", cells3, 64'd0);
      chk("ngm_count", mc3, 64'd0);
      chk("ngm_player", pl3, 64'd1);

      // Level-held new_game toggles the opener every edge (1->0->1->0)
      ng3 = 1'b1;
      tick(); tick(); tick();
      ng3 = 1'b0;
      chk("ngh_player", pl3, 64'd0);

      // 5x5, K=4: run of 3 does not win; rst during CHECK
      foreach (seq_a5[i]) press5(seq_a5[i]);
      chk("r3_over", go5, 64'd0);
      chk("r3_player", pl5, 64'd1);
      chk("r3_count", mc5, 64'd5);
      b5 = 25'd8;
      tick();
      b5 = 25'd0;
      rst5 = 1'b1;
      tick();
      rst5 = 1'b0;
      chk("rc_cells", cells5, 64'd0);
      chk("rc_count", mc5, 64'd0);
      chk("rc_player", pl5, 64'd0);
      chk("rc_over", go5, 64'd0);
      chk("rc_winner", win5, 64'd0);
      chk("rc_draw", dr5, 64'd0);

      // Vertical run at column 2, rows 1..4, by player0
      for (int i = 0; i < 6; i++) press5(seq_b5[i]);
      chk("v4_over_pre", go5, 64'd0);
      press5(seq_b5[6]);
      chk("v4_over", go5, 64'd1);
      chk("v4_winner", win5, 64'd0);
      chk("v4_draw", dr5, 64'd0);
      chk("v4_count", mc5, 64'd7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
